// File: rtl/goods_selector.sv
// -----------------------------------------------------------------------------
// goods_selector
//
// Product-selection front end for the vending machine. It registers the raw
// product buttons and edge-detects them, accepting one press at a time. The
// price of the pressed channel is looked up from a parameter table and
// converted to BCD for the display by a sequential shift-add-3 engine. The
// block keeps a stock counter per channel and holds the selection until
// payment/dispense reports vend completion or the user cancels.
//
// Ports
//   clk         in   system clock
//   rst         in   asynchronous reset, active-low
//   sel         in   [N_GOODS]      raw product buttons (level), bit i = channel i
//   cancel      in   user cancel, sampled synchronously
//   vend_done   in   one-cycle pulse: item delivered
//   restock     in   one-cycle pulse: reload every stock counter
//   sel_valid   out  a selection is locked (CONVERT or HOLD)
//   sel_onehot  out  [N_GOODS]      locked channel, one-hot; 0 when idle
//   price_bin   out  [PRICE_W]      locked price, binary; 0 when idle
//   price_bcd   out  [4*BCD_DIGITS] locked price, BCD; final only while bcd_valid
//   bcd_valid   out  price_bcd is final
//   reject      out  one-cycle pulse: a press was refused
//   sold_out    out  [N_GOODS]      bit i = 1 when channel i stock is 0
//   busy        out  BCD conversion in progress
// -----------------------------------------------------------------------------
module goods_selector #(
  parameter int N_GOODS    = 4,
  parameter int PRICE_W    = 8,
  parameter int BCD_DIGITS = 3,
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 9,
  parameter logic [N_GOODS*PRICE_W-1:0] PRICE_TABLE = {8'd10, 8'd7, 8'd5, 8'd2}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_GOODS-1:0]      sel,
  input  logic                    cancel,
  input  logic                    vend_done,
  input  logic                    restock,
  output logic                    sel_valid,
  output logic [N_GOODS-1:0]      sel_onehot,
  output logic [PRICE_W-1:0]      price_bin,
  output logic [4*BCD_DIGITS-1:0] price_bcd,
  output logic                    bcd_valid,
  output logic                    reject,
  output logic [N_GOODS-1:0]      sold_out,
  output logic                    busy
);

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(PRICE_W + 1);
  localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(PRICE_W - 1);
  localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(INIT_STOCK);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  // Double-dabble correction: every digit of 5 or more gets +3 before the
  // shift. No carry leaves the top digit because table prices fit the display.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (d[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Stock decrement that sticks at zero instead of wrapping.
  function automatic logic [STOCK_W-1:0] stock_dec_sat(input logic [STOCK_W-1:0] s);
    return (s == '0) ? '0 : (s - STOCK_W'(1));
  endfunction

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N_GOODS-1:0]   r_sel_q;
  logic [N_GOODS-1:0]   r_sel_prev;
  logic [1:0]           r_arm;
  logic [N_GOODS-1:0]   w_rise;
  logic                 w_rise_onehot;
  logic                 w_rise_soldout;
  logic [PRICE_W-1:0]   w_price;

  logic                 w_accept;
  logic                 w_reject;
  logic                 w_step;
  logic                 w_clear;
  logic                 w_vend;

  logic [N_GOODS-1:0]   r_sel_onehot;
  logic [PRICE_W-1:0]   r_price_bin;
  logic [PRICE_W-1:0]   r_shift;
  logic [BCD_W-1:0]     r_bcd;
  logic [BCD_W-1:0]     w_bcd_adj;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_reject;

  logic [STOCK_W-1:0]   r_stock [N_GOODS];
  logic [N_GOODS-1:0]   w_sold_out;

  // ---- input stage: button sampling and press detection ----
  // r_arm keeps press detection off until sel_prev holds a genuine sample
  // taken after reset, so a button held across reset counts as held rather
  // than as a fresh press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_q    <= '0;
      r_sel_prev <= '0;
      r_arm      <= 2'b00;
    end else begin
      r_sel_q    <= sel;
      r_sel_prev <= r_sel_q;
      r_arm      <= {r_arm[0], 1'b1};
    end
  end

  assign w_rise         = r_arm[1] ? (r_sel_q & ~r_sel_prev) : '0;
  assign w_rise_onehot  = (w_rise != '0) && ((w_rise & (w_rise - N_GOODS'(1))) == '0);
  assign w_rise_soldout = (w_rise & w_sold_out) != '0;

  always_comb begin
    w_price = '0;
    for (int i = 0; i < N_GOODS; i++) begin
      if (w_rise[i]) begin
        w_price = PRICE_TABLE[i*PRICE_W +: PRICE_W];
      end
    end
  end

  // ---- control: selection FSM ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_step      = 1'b0;
    w_clear     = 1'b0;
    w_vend      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise != '0) begin
          if (w_rise_onehot && !w_rise_soldout && !cancel) begin
            w_accept    = 1'b1;
            w_state_nxt = S_CONVERT;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_CONVERT: begin
        if (cancel) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == LAST_STEP) begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        // vend_done outranks a same-cycle cancel: the item is already out.
        if (vend_done) begin
          w_vend      = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (cancel) begin
          w_clear     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---- datapath: selection latch and shift-add-3 conversion ----
  assign w_bcd_adj = bcd_add3(r_bcd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_onehot <= '0;
      r_price_bin  <= '0;
      r_shift      <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_reject     <= 1'b0;
    end else begin
      r_reject <= w_reject;
      if (w_accept) begin
        r_sel_onehot <= w_rise;
        r_price_bin  <= w_price;
        r_shift      <= w_price;
        r_bcd        <= '0;
        r_cnt        <= '0;
      end else if (w_clear) begin
        r_sel_onehot <= '0;
        r_price_bin  <= '0;
        r_shift      <= '0;
        r_bcd        <= '0;
        r_cnt        <= '0;
      end else if (w_step) begin
        // Corrected digits shift left; the next price bit (MSB first) enters.
        r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[PRICE_W-1]};
        r_shift <= {r_shift[PRICE_W-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---- stock counters ----
  // Restock overrides a same-cycle vend so the counters always land on the
  // reload value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_GOODS; i++) begin
        r_stock[i] <= STOCK_RELOAD;
      end
    end else begin
      for (int i = 0; i < N_GOODS; i++) begin
        if (restock) begin
          r_stock[i] <= STOCK_RELOAD;
        end else if (w_vend && r_sel_onehot[i]) begin
          r_stock[i] <= stock_dec_sat(r_stock[i]);
        end
      end
    end
  end

  always_comb begin
    w_sold_out = '0;
    for (int i = 0; i < N_GOODS; i++) begin
      w_sold_out[i] = (r_stock[i] == '0);
    end
  end

  // ---- outputs ----
  assign sel_valid  = (r_state == S_CONVERT) || (r_state == S_HOLD);
  assign busy       = (r_state == S_CONVERT);
  assign bcd_valid  = (r_state == S_HOLD);
  assign sel_onehot = r_sel_onehot;
  assign price_bin  = r_price_bin;
  assign price_bcd  = r_bcd;
  assign reject     = r_reject;
  assign sold_out   = w_sold_out;

endmodule

// File: tb/tb_goods_selector.sv
module tb_goods_selector;

  localparam int N_GOODS    = 4;
  localparam int PRICE_W    = 8;
  localparam int BCD_DIGITS = 3;
  localparam int STOCK_W    = 4;
  localparam int INIT_STOCK = 2;

  logic                    clk;
  logic                    rst;
  logic [N_GOODS-1:0]      sel;
  logic                    cancel;
  logic                    vend_done;
  logic                    restock;
  logic                    sel_valid;
  logic [N_GOODS-1:0]      sel_onehot;
  logic [PRICE_W-1:0]      price_bin;
  logic [4*BCD_DIGITS-1:0] price_bcd;
  logic                    bcd_valid;
  logic                    reject;
  logic [N_GOODS-1:0]      sold_out;
  logic                    busy;

  int n_pass  = 0;
  int n_total = 0;

  goods_selector #(
    .N_GOODS    (N_GOODS),
    .PRICE_W    (PRICE_W),
    .BCD_DIGITS (BCD_DIGITS),
    .STOCK_W    (STOCK_W),
    .INIT_STOCK (INIT_STOCK),
    .PRICE_TABLE({8'd10, 8'd7, 8'd5, 8'd2})
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sel       (sel),
    .cancel    (cancel),
    .vend_done (vend_done),
    .restock   (restock),
    .sel_valid (sel_valid),
    .sel_onehot(sel_onehot),
    .price_bin (price_bin),
    .price_bcd (price_bcd),
    .bcd_valid (bcd_valid),
    .reject    (reject),
    .sold_out  (sold_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Press a button for one cycle and run until the selection reaches HOLD
  // (edge k+1+PRICE_W).
  task automatic press_to_hold(input logic [N_GOODS-1:0] mask);
    sel = mask;
    step();
    sel = '0;
    repeat (PRICE_W + 1) step();
  endtask

  task automatic vend_pulse();
    vend_done = 1'b1;
    step();
    vend_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sel       = '0;
    cancel    = 1'b0;
    vend_done = 1'b0;
    restock   = 1'b0;
    #2 rst = 1'b0;
    step();
    step();
    // reset state
    chk("rst_sel_valid",  32'(sel_valid),  32'd0);
    chk("rst_sel_onehot", 32'(sel_onehot), 32'd0);
    chk("rst_price_bin",  32'(price_bin),  32'd0);
    chk("rst_price_bcd",  32'(price_bcd),  32'd0);
    chk("rst_bcd_valid",  32'(bcd_valid),  32'd0);
    chk("rst_reject",     32'(reject),     32'd0);
    chk("rst_sold_out",   32'(sold_out),   32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    rst = 1'b1;
    repeat (3) step();

    // channel 2, price 7
    sel = 4'b0100;
    step();                                    // edge k
    sel = '0;
    chk("c2_k_sel_valid", 32'(sel_valid), 32'd0);
    step();                                    // edge k+1
    chk("c2_k1_sel_valid", 32'(sel_valid),  32'd1);
    chk("c2_k1_busy",      32'(busy),       32'd1);
    chk("c2_k1_onehot",    32'(sel_onehot), 32'h4);
    chk("c2_k1_price_bin", 32'(price_bin),  32'd7);
    repeat (7) step();                         // edge k+8
    chk("c2_k8_bcd_valid", 32'(bcd_valid), 32'd0);
    step();                                    // edge k+9
    chk("c2_k9_bcd_valid", 32'(bcd_valid), 32'd1);
    chk("c2_k9_price_bcd", 32'(price_bcd), 32'h007);
    chk("c2_k9_busy",      32'(busy),      32'd0);
    vend_pulse();
    chk("c2_vend_sel_valid", 32'(sel_valid), 32'd0);
    chk("c2_vend_onehot",    32'(sel_onehot), 32'd0);
    chk("c2_vend_price_bin", 32'(price_bin), 32'd0);
    chk("c2_vend_price_bcd", 32'(price_bcd), 32'd0);
    chk("c2_vend_bcd_valid", 32'(bcd_valid), 32'd0);
    chk("c2_vend_sold_out",  32'(sold_out),  32'd0);

    // channel 3, price 10; press during HOLD ignored; cancel
    press_to_hold(4'b1000);
    chk("c3_price_bcd", 32'(price_bcd), 32'h010);
    chk("c3_price_bin", 32'(price_bin), 32'd10);
    sel = 4'b0001;
    step();
    sel = '0;
    chk("hold_press_reject_a", 32'(reject), 32'd0);
    step();
    chk("hold_press_reject_b", 32'(reject),     32'd0);
    chk("hold_press_onehot",   32'(sel_onehot), 32'h8);
    chk("hold_press_bcd",      32'(price_bcd),  32'h010);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("c3_cancel_sel_valid", 32'(sel_valid), 32'd0);
    chk("c3_cancel_price_bin", 32'(price_bin), 32'd0);
    chk("c3_cancel_price_bcd", 32'(price_bcd), 32'd0);
    chk("c3_cancel_bcd_valid", 32'(bcd_valid), 32'd0);

    // two buttons rising together
    sel = 4'b0011;
    step();
    sel = '0;
    chk("multi_k_reject", 32'(reject), 32'd0);
    step();
    chk("multi_k1_reject",    32'(reject),    32'd1);
    chk("multi_k1_sel_valid", 32'(sel_valid), 32'd0);
    step();
    chk("multi_k2_reject",    32'(reject),    32'd0);
    chk("multi_k2_sel_valid", 32'(sel_valid), 32'd0);

    // stock exhaustion (INIT_STOCK = 2)
    press_to_hold(4'b0001);
    chk("c0_price_bcd", 32'(price_bcd), 32'h002);
    vend_pulse();
    chk("c0_vend1_sold_out", 32'(sold_out), 32'h0);
    press_to_hold(4'b0001);
    vend_pulse();
    chk("c0_vend2_sold_out", 32'(sold_out), 32'h1);
    press_to_hold(4'b0100);                    // channel 2 had one vend earlier
    vend_pulse();
    chk("c2_vend2_sold_out", 32'(sold_out), 32'h5);
    press_to_hold(4'b1000);                    // cancelled earlier: still 2 left
    vend_pulse();
    chk("c3_vend1_sold_out", 32'(sold_out), 32'h5);
    sel = 4'b0001;
    step();
    sel = '0;
    step();
    chk("soldout_reject",    32'(reject),    32'd1);
    chk("soldout_sel_valid", 32'(sel_valid), 32'd0);
    restock = 1'b1;
    step();
    restock = 1'b0;
    chk("restock_sold_out", 32'(sold_out), 32'h0);
    sel = 4'b0001;
    step();
    sel = '0;
    step();
    chk("restock_accept_sel_valid", 32'(sel_valid), 32'd1);
    chk("restock_accept_reject",    32'(reject),    32'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("restock_cancel_sel_valid", 32'(sel_valid), 32'd0);

    // cancel in the 3rd CONVERT cycle (channel 1, price 5)
    sel = 4'b0010;
    step();                                    // edge k
    sel = '0;
    step();                                    // k+1: CONVERT cycle 1
    step();                                    // k+2: cycle 2
    step();                                    // k+3: cycle 3
    chk("conv3_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    chk("conv_abort_sel_valid", 32'(sel_valid), 32'd0);
    chk("conv_abort_busy",      32'(busy),      32'd0);
    chk("conv_abort_price_bin", 32'(price_bin), 32'd0);
    for (int i = 0; i < PRICE_W; i++) begin
      step();
      chk("conv_abort_no_bcd_valid", 32'(bcd_valid), 32'd0);
    end

    // vend_done + cancel together in HOLD: the vend counts
    press_to_hold(4'b0010);
    chk("c1_price_bcd", 32'(price_bcd), 32'h005);
    vend_done = 1'b1;
    cancel    = 1'b1;
    step();
    vend_done = 1'b0;
    cancel    = 1'b0;
    chk("vend_cancel_sel_valid", 32'(sel_valid), 32'd0);
    chk("vend_cancel_sold_out",  32'(sold_out),  32'h0);
    press_to_hold(4'b0010);
    vend_pulse();
    chk("c1_second_vend_sold_out", 32'(sold_out), 32'h2);

    // async reset mid-HOLD with the button kept held
    sel = 4'b0100;
    step();
    repeat (PRICE_W + 1) step();
    chk("pre_rst_bcd_valid", 32'(bcd_valid), 32'd1);
    chk("pre_rst_sold_out",  32'(sold_out),  32'h2);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_sel_valid", 32'(sel_valid), 32'd0);
    chk("async_rst_price_bin", 32'(price_bin), 32'd0);
    chk("async_rst_bcd_valid", 32'(bcd_valid), 32'd0);
    chk("async_rst_sold_out",  32'(sold_out),  32'h0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_no_trigger_sel_valid", 32'(sel_valid), 32'd0);
      chk("held_no_trigger_reject",    32'(reject),    32'd0);
    end
    sel = '0;
    step();
    step();
    sel = 4'b0100;
    step();
    sel = '0;
    step();
    chk("repress_sel_valid", 32'(sel_valid),  32'd1);
    chk("repress_onehot",    32'(sel_onehot), 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/goods_selector.md
Name: goods_selector

Overview:
Parametrised product-selection block for the vending machine. It registers the N product buttons and accepts one press at a time. It looks up the price from a parameter table and converts that price to BCD with a sequential shift-add-3 engine for the display. It also tracks per-channel stock, and holds the selection until the payment/dispense logic reports vend completion or the user cancels.

Parameters:
N_GOODS, 4, number of product channels/buttons
PRICE_W, 8, binary price width (yuan)
BCD_DIGITS, 3, BCD digits on price_bcd
STOCK_W, 4, per-channel stock counter width
INIT_STOCK, 9, stock loaded at reset and on restock (must be < 2^STOCK_W)
PRICE_TABLE, {8'd10,8'd7,8'd5,8'd2}, packed N_GOODS*PRICE_W; channel i at [i*PRICE_W +: PRICE_W]; every entry <= 10^BCD_DIGITS-1

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
sel  in  N_GOODS  raw product buttons, level, bit i = channel i
cancel  in  1  user cancel, sampled synchronously
vend_done  in  1  one-cycle pulse from payment/dispense: item delivered
restock  in  1  one-cycle pulse: reload all stock counters
sel_valid  out  1  a selection is locked (CONVERT or HOLD)
sel_onehot  out  N_GOODS  locked channel, one-hot; 0 when idle
price_bin  out  PRICE_W  locked price, binary; 0 when idle
price_bcd  out  4*BCD_DIGITS  locked price, BCD; valid only while bcd_valid
bcd_valid  out  1  price_bcd is final
reject  out  1  one-cycle pulse: press ignored
sold_out  out  N_GOODS  bit i = 1 when stock of channel i is 0
busy  out  1  high in CONVERT

Behaviour:
- Reset (rst low, async): state IDLE. sel_q = 0 and sel_prev = 0. All outputs 0 except sold_out = 0. All stock counters = INIT_STOCK.
- Input stage: sel_q <= sel every clock and sel_prev <= sel_q. A press is rise = sel_q & ~sel_prev.
- States: IDLE, CONVERT, HOLD.
- IDLE, rise != 0:
  - Accept when rise is exactly one-hot, the channel is not sold out, and cancel = 0.
  - On accept: latch sel_onehot and price_bin from PRICE_TABLE, clear the BCD shift register, go to CONVERT.
  - Otherwise (multi-bit rise, sold-out channel, or cancel = 1): reject = 1 for one cycle and stay in IDLE.
- CONVERT:
  - One double-dabble step per clock, MSB first. For each BCD digit >= 5, add 3, then shift left one bit and feed in the next price bit.
  - Runs for exactly PRICE_W cycles, then HOLD with bcd_valid = 1. busy = 1 throughout.
- Latency: sel rises before edge k, so sel_q = 1 at k and sel_valid = 1 from edge k+1. bcd_valid = 1 from edge k+1+PRICE_W (k+9 at default).
- HOLD: selection is locked; all new presses are ignored with no reject.
  - vend_done = 1: decrement the locked channel's stock, saturating at 0. Then IDLE, clearing sel_onehot, price_bin, price_bcd and bcd_valid.
  - cancel = 1: IDLE with the same clears; stock unchanged.
  - vend_done and cancel in the same cycle: vend_done wins.
- CONVERT + cancel: abort to IDLE next edge with outputs cleared. vend_done in CONVERT or IDLE is ignored.
- restock: all counters = INIT_STOCK next edge, in any state, with no effect on the FSM. Restock with a same-cycle vend_done: counters = INIT_STOCK, i.e. restock wins; the FSM still returns to IDLE.
- sold_out is combinational from the counters. A channel that reaches 0 while held still completes its vend.
- A held button does not re-trigger; only a 0->1 transition counts. A button held through IDLE re-entry does not generate a new press.
- Arithmetic:
  - BCD digits use 4-bit add-3 with no carry out of the top digit, relying on the table constraint.
  - Stock decrement is saturating and never wraps.

Test Plan:
- Reset, then press sel=4'b0100 -> sel_valid=1 at k+1; after 8 CONVERT cycles price_bin=7, price_bcd=12'h007, bcd_valid=1; vend_done pulse -> IDLE, channel 2 stock 9->8.
- Press sel=4'b1000 -> price_bcd=12'h010 after 8 cycles. Press 4'b0001 while in HOLD -> ignored, no reject; cancel -> all outputs 0, stock unchanged.
- sel=4'b0011 pressed in the same cycle in IDLE -> reject pulse for one cycle, state IDLE, sel_valid stays 0.
- INIT_STOCK=2: two full vends on channel 0 -> sold_out[0]=1; third press -> reject. Then restock -> sold_out=0 and the press is accepted.
- Cancel at 3rd CONVERT cycle -> IDLE next edge, bcd_valid never asserts. vend_done+cancel together in HOLD -> stock decremented (vend wins).
- rst low mid-HOLD -> outputs 0 immediately (async), stock back to INIT_STOCK; after release, a held button does not trigger until released and re-pressed.
